// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Also provides the load-use detector interface widths.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REGW_DEF = 5;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_MDWAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_bubble;
    logic exmem_bubble;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_lu_hazard_det.sv
// Load-use hazard detector: ID reads a register a load in EX is still producing.
// Shared with the forwarding unit.
module lu_hazard_det
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  output logic            lu_hz
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign lu_hz   = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use stall, mul/div hold,
// branch redirect flush, plus saturating stall/flush perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REGW   = REGW_DEF,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNTW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            md_start,
  input  logic            md_done,
  input  logic            br_taken,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_stall,
  output logic            idex_bubble,
  output logic            exmem_bubble,
  output logic            busy,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  // Remaining hold cycles need to cover MD_LAT-2 down to 0.
  localparam int unsigned MCW = (MD_LAT > 2) ? $clog2(MD_LAT - 1) : 1;
  localparam logic [MCW-1:0] MD_INIT = MCW'(MD_LAT - 2);

  if (MD_LAT < 2) begin : g_md_lat_check
    $error("pipe_hazard_ctrl: MD_LAT must be at least 2");
  end

  hz_state_e state, state_nxt;
  logic [MCW-1:0] cnt, cnt_nxt;
  hz_ctrl_t ctrl, ctrl_q;
  logic lu_hz;

  lu_hazard_det #(.REGW(REGW)) u_lu_det (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .lu_hz       (lu_hz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and control decode; priority br_taken > md_start > lu_hz in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ctrl      = '0;
    unique case (state)
      HZ_RUN: begin
        if (br_taken) begin
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end else if (md_start) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.ifid_stall   = 1'b1;
          ctrl.idex_stall   = 1'b1;
          ctrl.exmem_bubble = 1'b1;
          state_nxt         = HZ_MDWAIT;
          cnt_nxt           = MD_INIT;
        end else if (lu_hz) begin
          ctrl.pc_stall    = 1'b1;
          ctrl.ifid_stall  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
      end
      HZ_MDWAIT: begin
        if (md_done || (cnt == '0)) begin
          state_nxt = HZ_RUN;
        end else begin
          ctrl.pc_stall     = 1'b1;
          ctrl.ifid_stall   = 1'b1;
          ctrl.idex_stall   = 1'b1;
          ctrl.exmem_bubble = 1'b1;
          cnt_nxt           = cnt - MCW'(1);
        end
      end
      default: state_nxt = HZ_RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign ctrl_q       = rst_n ? ctrl : '0;
  assign pc_stall     = ctrl_q.pc_stall;
  assign ifid_stall   = ctrl_q.ifid_stall;
  assign ifid_flush   = ctrl_q.ifid_flush;
  assign idex_stall   = ctrl_q.idex_stall;
  assign idex_bubble  = ctrl_q.idex_bubble;
  assign exmem_bubble = ctrl_q.exmem_bubble;
  assign busy         = rst_n && (state == HZ_MDWAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNTW{1'b1}})) stall_cnt <= stall_cnt + CNTW'(1);
      if (ifid_flush && (flush_cnt != {CNTW{1'b1}})) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + random bench for pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REGW   = 5;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNTW   = 4;
  localparam int          SAT    = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [REGW-1:0] id_rs1, id_rs2, ex_rd;
  logic            id_uses_rs1, id_uses_rs2, ex_is_load;
  logic            md_start, md_done, br_taken;
  logic            pc_stall, ifid_stall, ifid_flush, idex_stall;
  logic            idex_bubble, exmem_bubble, busy;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(REGW), .MD_LAT(MD_LAT), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .md_start     (md_start),
    .md_done      (md_done),
    .br_taken     (br_taken),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_stall   (idex_stall),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .busy         (busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference: md_left = cycles the mul/div still stays in EX after this one (0 = free).
  int md_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic model_lu();
    return ex_is_load && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_bubble, busy}
  function automatic logic [6:0] model_ctrl();
    if (!rst_n) return 7'b0;
    if (md_left == 0) begin
      if (br_taken) return 7'b0010100;
      if (md_start) return 7'b1101010;
      if (model_lu()) return 7'b1100100;
      return 7'b0;
    end
    if (md_done || md_left == 1) return 7'b0000001;
    return 7'b1101011;
  endfunction

  task automatic model_edge();
    logic [6:0] e;
    e = model_ctrl();
    if (!rst_n) return;
    if (e[6] && m_stall < SAT) m_stall++;
    if (e[4] && m_flush < SAT) m_flush++;
    if (md_left == 0) begin
      if (!br_taken && md_start) md_left = MD_LAT - 1;
    end else if (md_done || md_left == 1) begin
      md_left = 0;
    end else begin
      md_left--;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ctrl"}, 32'({pc_stall, ifid_stall, ifid_flush, idex_stall,
                               idex_bubble, exmem_bubble, busy}), 32'(model_ctrl()));
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
  endtask

  // Check at negedge with current inputs, advance the model, move past the next edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_is_load = 0; md_start = 0; md_done = 0; br_taken = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs1, then the load leaves EX.
    ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
    cycle("lu_hit");
    ex_is_load = 0;
    cycle("lu_clear");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_is_load = 1; ex_rd = 5'd0; id_rs1 = 5'd0;
    cycle("lu_x0");
    check("lu_x0_cnt", 32'(stall_cnt), 32'd1);
    clr_in();

    // Full-latency mul/div: 3 stall cycles then release.
    md_start = 1;
    for (int i = 0; i < MD_LAT; i++) cycle($sformatf("md_full%0d", i));
    md_start = 0;
    check("md_full_cnt", 32'(stall_cnt), 32'd4);
    cycle("md_full_after");

    // Early done in the cycle after md_start.
    md_start = 1;
    cycle("md_early0");
    md_done = 1;
    cycle("md_early1");
    md_start = 0; md_done = 0;
    check("md_early_cnt", 32'(stall_cnt), 32'd5);
    cycle("md_early_run");

    // Back-to-back mul/div with md_start held across the release.
    md_start = 1;
    for (int i = 0; i < 2 * MD_LAT; i++) cycle($sformatf("md_b2b%0d", i));
    md_start = 0;
    check("md_b2b_cnt", 32'(stall_cnt), 32'd11);
    cycle("md_b2b_run");

    // Branch wins over md_start and load-use.
    br_taken = 1; md_start = 1;
    ex_is_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1;
    cycle("br_prio");
    clr_in();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    cycle("br_stay_run");

    // Asynchronous reset mid mul/div wait.
    md_start = 1;
    cycle("rst_md0");
    cycle("rst_md1");
    @(negedge clk);
    check_all("rst_md2");
    #1;
    rst_n = 1'b0;
    md_left = 0; m_stall = 0; m_flush = 0;
    #1;
    check("rst_async_ctrl", 32'({pc_stall, ifid_stall, ifid_flush, idex_stall,
                                 idex_bubble, exmem_bubble, busy}), 32'd0);
    check("rst_async_cnt", 32'({stall_cnt, flush_cnt}), 32'd0);
    md_start = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("rst_after");

    // Saturation: fill to SAT-1 then three more stalls.
    ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1;
    for (int i = 0; i < SAT - 1; i++) cycle("sat_fill");
    check("sat_pre", 32'(stall_cnt), 32'(SAT - 1));
    for (int i = 0; i < 3; i++) cycle("sat_top");
    check("sat_hold", 32'(stall_cnt), 32'(SAT));
    clr_in();

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 60) == 0) begin
        rst_n = 1'b0;
        md_left = 0; m_stall = 0; m_flush = 0;
      end else begin
        rst_n = 1'b1;
      end
      id_rs1      = REGW'($urandom_range(0, 3));
      id_rs2      = REGW'($urandom_range(0, 3));
      ex_rd       = REGW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      md_start    = ($urandom_range(0, 4) == 0);
      md_done     = ($urandom_range(0, 3) == 0);
      br_taken    = ($urandom_range(0, 6) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
